// File: rtl/hilo_unit.sv
// hilo_unit: issues mult/div ops, captures results into HI/LO and stalls readers while busy
module hilo_unit #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic        stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        mul_ena,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_done
);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic          uns;
    logic          is_mul;
    logic          is_div;
    logic          is_cmd;
    logic [63:0]   prod;

    assign is_mul = op_valid & (op_code == 3'd1 | op_code == 3'd2);
    assign is_div = op_valid & (op_code == 3'd3 | op_code == 3'd4);
    assign is_cmd = op_valid & (op_code != 3'd0) & (op_code != 3'd7);
    assign mul_a  = op_a;
    assign mul_b  = op_b;
    assign div_a  = op_a;
    assign div_b  = op_b;
    assign stall  = (state != S_IDLE) & (rd_hi | rd_lo | is_cmd);

    // Turn the signed multiplier product into an unsigned one by adding back the sign-weighted cross terms
    always_comb begin
        prod = mul_z;
        if (uns)
            prod = mul_z + {(op_a[31] ? op_b : 32'd0), 32'd0} + {(op_b[31] ? op_a : 32'd0), 32'd0};
    end

    // Control FSM: accept commands in IDLE, wait out the multiplier count or the divider done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            uns        <= 1'b0;
            hi_out     <= '0;
            lo_out     <= '0;
            mul_ena    <= 1'b0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        op_a    <= rs_val;
                        op_b    <= rt_val;
                        uns     <= (op_code == 3'd2);
                        cnt     <= CW'(MUL_LAT);
                        mul_ena <= 1'b1;
                        state   <= S_MUL;
                    end else if (is_div) begin
                        op_a       <= rs_val;
                        op_b       <= rt_val;
                        div_signed <= (op_code == 3'd3);
                        if (rt_val != 32'd0) begin
                            div_start <= 1'b1;
                            state     <= S_DIV;
                        end
                    end else if (op_valid && op_code == 3'd5) begin
                        hi_out <= rs_val;
                    end else if (op_valid && op_code == 3'd6) begin
                        lo_out <= rs_val;
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        {hi_out, lo_out} <= prod;
                        mul_ena          <= 1'b0;
                        state            <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    div_start <= 1'b0;
                    if (div_done) begin
                        lo_out <= div_q;
                        hi_out <= div_r;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: randomized and directed checks of hilo_unit against an arithmetic HI/LO model
module tb_hilo_unit;
    localparam int MUL_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        rd_hi = 1'b0;
    logic        rd_lo = 1'b0;
    logic        stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        mul_ena;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z = '0;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q = '0;
    logic [31:0] div_r = '0;
    logic        div_done = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          div_lat = 1;
    int          dcnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .stall(stall), .hi_out(hi_out), .lo_out(lo_out),
        .mul_ena(mul_ena), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_done(div_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mulres(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        return sgn ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    function automatic logic [63:0] divres(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    // multiplier stand-in: one registered stage of signed product while enabled
    always @(posedge clk) if (mul_ena) mul_z <= mulres(mul_a, mul_b, 1'b1);

    // divider stand-in: done pulse div_lat edges after the start edge, ignores reset
    always @(posedge clk) begin
        logic [63:0] res;
        div_done <= 1'b0;
        if (div_start) dcnt <= div_lat;
        else if (dcnt > 0) dcnt <= dcnt - 1;
        if (!div_start && dcnt == 1) begin
            res = divres(div_a, div_b, div_signed);
            div_done <= 1'b1;
            div_q    <= res[31:0];
            div_r    <= res[63:32];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit rd, input int dlat);
        logic [63:0] p;
        bit          is_mul, is_div;
        is_mul  = (op == 3'd1 || op == 3'd2);
        is_div  = (op == 3'd3 || op == 3'd4);
        div_lat = dlat;
        op_valid = 1'b1; op_code = op; rs_val = rs; rt_val = rt; rd_hi = rd; rd_lo = 1'b0;
        #1;
        chk("idle_stall", stall, 0);
        chk("idle_hi", hi_out, m_hi);
        chk("idle_lo", lo_out, m_lo);
        chk("idle_mul_ena", mul_ena, 0);
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'd0; rd_hi = 1'b0; rd_lo = rd;
        if (is_mul) begin
            p = mulres(rs, rt, op == 3'd1);
            m_hi = p[63:32]; m_lo = p[31:0];
            for (int i = 0; i <= MUL_LAT; i++) begin
                #1;
                chk("mul_ena", mul_ena, 1);
                chk("mul_a", mul_a, rs);
                chk("mul_b", mul_b, rt);
                chk("mul_stall", stall, rd);
                @(negedge clk);
            end
            #1 chk("mul_ena_off", mul_ena, 0);
        end else if (is_div && rt != 32'd0) begin
            p = divres(rs, rt, op == 3'd3);
            m_hi = p[63:32]; m_lo = p[31:0];
            for (int i = 0; i < dlat + 2; i++) begin
                #1;
                chk("div_start", div_start, i == 0);
                chk("div_signed", div_signed, op == 3'd3);
                chk("div_a", div_a, rs);
                chk("div_b", div_b, rt);
                chk("div_stall", stall, rd);
                @(negedge clk);
            end
            #1 chk("div_start_off", div_start, 0);
        end else begin
            if (op == 3'd5) m_hi = rs;
            if (op == 3'd6) m_lo = rs;
            #1 chk("no_unit_start", div_start | mul_ena, 0);
        end
        rd_lo = 1'b1;
        #1;
        chk("done_stall", stall, 0);
        chk("hi", hi_out, m_hi);
        chk("lo", lo_out, m_lo);
        rd_lo = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        #1 reset = 1'b1;
        rd_hi = 1'b1; rd_lo = 1'b1; op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd3; rt_val = 32'd3;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        chk("rst_div_start", div_start, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mul_ena", mul_ena, 0);
        reset = 1'b0; op_valid = 1'b0; op_code = 3'd0; rd_hi = 1'b0; rd_lo = 1'b0;
        @(negedge clk);

        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1);
        chk("t1_hi", hi_out, 32'hFFFFFFFF);
        chk("t1_lo", lo_out, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1);
        chk("t2_hi", hi_out, 32'h00000001);
        run_op(3'd1, 32'h80000000, 32'h80000000, 1'b1, 1);
        chk("t3_hi", hi_out, 32'h40000000);
        chk("t3_lo", lo_out, 32'h0);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 33);
        chk("t4_lo", lo_out, 32'hFFFFFFFD);
        chk("t4_hi", hi_out, 32'hFFFFFFFF);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 33);
        chk("t5_lo", lo_out, 32'h7FFFFFFC);
        chk("t5_hi", hi_out, 32'h1);

        op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd5; rt_val = 32'd7;
        @(negedge clk);
        op_code = 3'd5; rs_val = 32'h1234;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!stall) break;
            cnt++;
            @(negedge clk);
        end
        chk("mthi_stall_cycles", cnt, MUL_LAT + 1);
        chk("mthi_lo_prod", lo_out, 32'd35);
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'd0;
        #1;
        chk("mthi_applied", hi_out, 32'h1234);
        m_hi = 32'h1234; m_lo = 32'd35;
        @(negedge clk);

        run_op(3'd5, 32'hAAAA, 32'd0, 1'b1, 1);
        run_op(3'd6, 32'h5555, 32'd0, 1'b0, 1);
        run_op(3'd3, 32'd100, 32'd0, 1'b1, 1);
        chk("div0_hi", hi_out, 32'hAAAA);
        chk("div0_lo", lo_out, 32'h5555);

        for (int k = 0; k < 40; k++)
            run_op(3'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(1, 6));

        run_op(3'd5, 32'hBEEF, 32'd0, 1'b0, 1);
        run_op(3'd6, 32'hCAFE, 32'd0, 1'b0, 1);
        div_lat = 20;
        op_valid = 1'b1; op_code = 3'd3; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
        @(negedge clk);
        op_valid = 1'b0; op_code = 3'd0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1; rd_hi = 1'b1;
        #1;
        chk("mid_rst_hi", hi_out, 0);
        chk("mid_rst_lo", lo_out, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_div_signed", div_signed, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        chk("late_done_hi", hi_out, 0);
        chk("late_done_lo", lo_out, 0);
        chk("late_done_stall", stall, 0);
        rd_hi = 1'b0;
        @(negedge clk);
        run_op(3'd1, 32'd3, 32'd4, 1'b1, 1);
        chk("post_rst_lo", lo_out, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Issue/writeback controller for the CPU's multiply/divide path; sits downstream of the 32x32 signed Booth multiplier and the iterative divider.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage and drives the arithmetic units.
- Captures results into architectural HI/LO, serves MFHI/MFLO, and stalls the pipeline while an operation is outstanding.

Parameters:
- MUL_LAT, 1, multiplier cycles from first mul_ena edge to valid mul_z (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  command strobe from execute stage.
- op_code  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- rs_val  input  32  operand a / MTHI/MTLO source.
- rt_val  input  32  operand b.
- rd_hi  input  1  MFHI in execute.
- rd_lo  input  1  MFLO in execute.
- stall  output  1  hold pipeline.
- hi_out  output  32  HI register.
- lo_out  output  32  LO register.
- mul_ena  output  1  multiplier enable.
- mul_a  output  32  multiplier operand a.
- mul_b  output  32  multiplier operand b.
- mul_z  input  64  signed product.
- div_start  output  1  one-cycle divider start pulse.
- div_signed  output  1  1 = DIV, 0 = DIVU.
- div_a  output  32  dividend.
- div_b  output  32  divisor.
- div_q  input  32  quotient.
- div_r  input  32  remainder.
- div_done  input  1  one-cycle result-valid pulse.

Behaviour:
- Reset (any time, including mid-operation) forces:
  - State IDLE; cnt 0.
  - HI, LO, latched operands, and the unsigned flag to 0.
  - stall, mul_ena, div_start, div_signed to 0.
  - In-flight result discarded; a later div_done is ignored in IDLE.
- States:
  - IDLE: accept commands.
  - MUL: multiply outstanding.
  - DIV: divide outstanding.
- IDLE transitions and actions:
  - op_valid & MULT/MULTU: latch rs->A, rt->B, uns = (op==MULTU); cnt <= MUL_LAT; go to MUL.
  - op_valid & DIV/DIVU: latch A, B, div_signed.
    - If rt_val==0: go nowhere; HI/LO unchanged; no stall; no div_start.
    - Otherwise go to DIV.
  - MTHI: HI <= rs_val at the edge. MTLO: LO <= rs_val at the edge. No stall.
  - NOP/7: no action.
- MUL state:
  - mul_ena = 1 and mul_a/mul_b = A/B, held stable the whole state.
  - cnt decrements each cycle.
  - In the cycle with cnt==0: capture {HI,LO} <= P at the edge, go to IDLE.
  - Total busy time: MUL_LAT+1 cycles.
- DIV state:
  - div_a/div_b = A/B, held stable.
  - div_start = 1 only in the first DIV cycle.
  - On div_done: LO <= div_q, HI <= div_r, go to IDLE.
  - No timeout.
- Product correction (mod 2^64), applied only when uns=1; signed ops use mul_z directly:
  - P = mul_z + ((A[31] ? B : 0) << 32) + ((B[31] ? A : 0) << 32).
- Stall rules:
  - stall = (state != IDLE) & (rd_hi | rd_lo | (op_valid & op_code in 1..6)).
  - Any command presented while busy is ignored; the pipeline re-presents it once stall drops.
  - NOP with no read while busy produces no stall; independent instructions proceed.
- Capture edge: stall deasserts combinationally in the cycle after the capture edge. The held MFHI/MFLO then sees the new HI/LO.
- hi_out/lo_out are direct register outputs. Same-cycle MTHI + rd_hi in IDLE returns the old HI; the new value appears next cycle.
- Capture-edge conflict: a div_done arriving in the same cycle as a new command is impossible (command is stalled). The capture has priority.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002, MUL_LAT=1 -> stall 0; after 2 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; mul_ena high exactly 2 cycles.
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE. Also MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2, bench divider done after 33 cycles -> div_start single pulse, div_signed=1, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- MULT then MFLO next cycle -> stall high until capture, then lo_out correct. MTHI 0x1234 presented during MUL is stalled, then applied: HI=0x1234 after product captured.
- DIV with rt=0 after MTHI 0xAAAA/MTLO 0x5555 -> no div_start, no stall; HI=0xAAAA, LO=0x5555 unchanged.
- Reset asserted mid-DIV, then late div_done -> state IDLE; HI=LO=0; stall=0; div_done ignored; next MULT 3*4 gives LO=12.
